// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic increment/scale pipeline.
package pipe_pkg;

    localparam int PIPE_WIDTH_DEF = 8;
    localparam int PIPE_DEPTH_DEF = 8;
    localparam int PIPE_INC_DEF   = 1;
    localparam int PIPE_SCALE_DEF = 2;

    // Width of a counter that must represent 0..depth+1 words in flight.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic slot: a valid bit plus a data word.
// When adv is high, the slot loads upstream data plus INC.
// When adv is low, the slot holds its contents.
module elastic_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] INC   = WIDTH'(PIPE_INC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             adv,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    // Slot register: clear on reset, load when allowed to advance, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (adv) begin
            r_v <= up_valid;
            r_d <= up_data + INC;
        end
    end

    assign v = r_v;
    assign d = r_d;

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic pipeline with DEPTH increment stages and a scaling output register.
//
// Output: out_data = ((in + DEPTH*INC) * SCALE) mod 2^WIDTH.
//
// Optional feature (macro PIPE_OCCUPANCY_EN): adds an occupancy port.
// This port is a registered count of the words currently in flight.
//
// Handshake: a word moves across a boundary only on a cycle where
// valid && ready is high at the clock edge.
//   - A producer may not retract valid or change data while waiting.
//   - A slot that is full and blocked downstream keeps its word unchanged.
//
// Ready is a purely combinational chain from out_ready back to in_ready.
// Because of that, a full pipe can accept and deliver in the same cycle.
module elastic_pipeline
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF,
    parameter int INC   = PIPE_INC_DEF,
    parameter int SCALE = PIPE_SCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [WIDTH-1:0] SCALE_W = WIDTH'(SCALE);

    // Slot valid/data from the increment stages.
    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];

    // w_adv[k]: slot k may load from upstream this cycle.
    // Index DEPTH is the output register.
    logic [DEPTH:0]   w_adv;

    // Output register.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_prod;

    // Ready chain: a slot advances if it is empty or its downstream slot advances.
    always_comb begin
        w_adv[DEPTH] = !r_out_valid || out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k] = !w_v[k] || w_adv[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (k == 0) begin : g_first
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_rest
            assign w_up_valid = w_v[k-1];
            assign w_up_data  = w_d[k-1];
        end

        elastic_stage #(
            .WIDTH (WIDTH),
            .INC   (INC_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (w_up_valid),
            .up_data  (w_up_data),
            .adv      (w_adv[k]),
            .v        (w_v[k]),
            .d        (w_d[k])
        );
    end

    // The product is truncated to WIDTH bits, so wrap-around is silent.
    assign w_prod = WIDTH'(w_d[DEPTH-1] * SCALE_W);

    // Output register: load the scaled last-stage word when it may advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv[DEPTH]) begin
            r_out_valid <= w_v[DEPTH-1];
            r_out_data  <= w_prod;
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    assign w_in_xfer  = in_valid && w_adv[0];
    assign w_out_xfer = r_out_valid && out_ready;

    // Occupancy counter: +1 per accepted word, -1 per delivered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Testbench for elastic_pipeline. Uses DEPTH=8 when PIPE_OCCUPANCY_EN is
// defined, otherwise DEPTH=2. Driver tasks push expected results into
// exp_q; an independent monitor pops and compares delivered words.
module tb_elastic_pipeline;

    localparam int W     = 8;
`ifdef PIPE_OCCUPANCY_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 2;
`endif
    localparam int INC   = 1;
    localparam int SCALE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
    logic [$clog2(DEPTH+2)-1:0] occupancy;
`endif

    logic [W-1:0] exp_q[$];
    int           n_cmp   = 0;
    int           n_err   = 0;
    int           acc_cnt = 0;
    int           del_cnt = 0;
    int           run_len = 0;
    int           max_run = 0;
    logic         have_hold = 1'b0;
    logic [W-1:0] hold_val = '0;

    elastic_pipeline #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .INC   (INC),
        .SCALE (SCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model: add DEPTH*INC, then scale, all modulo 2^W.
    function automatic logic [W-1:0] model(input logic [W-1:0] x);
        int r;
        r = ((int'(x) + DEPTH * INC) * SCALE) % (1 << W);
        return W'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; report whether the word was accepted.
    task automatic drive(input logic v, input logic [W-1:0] dat, input logic ordy,
                         output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = dat;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(model(dat));
            acc_cnt++;
        end
    endtask

    task automatic drain();
        logic a;
        int   k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            drive(1'b0, '0, 1'b1, a);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        drive(1'b0, '0, 1'b1, a);
        drive(1'b0, '0, 1'b1, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        acc_cnt   = 0;
        del_cnt   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef PIPE_OCCUPANCY_EN
        check("rst_occupancy", occupancy, 0);
`endif
    endtask

    // Output monitor: compare delivered words, check stall stability, track runs.
    always @(negedge clk) begin
        if (rst) begin
            have_hold = 1'b0;
            run_len   = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0d expected none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                del_cnt++;
                have_hold = 1'b0;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
                if (out_valid) begin
                    if (have_hold) check("stall_hold", out_data, hold_val);
                    hold_val  = out_data;
                    have_hold = 1'b1;
                end
            end
        end
    end

`ifdef PIPE_OCCUPANCY_EN
    // Occupancy must equal accepted minus delivered, and never exceed DEPTH+1.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("occupancy", occupancy, acc_cnt - del_cnt);
            check("occ_max", 32'(occupancy <= DEPTH + 1), 1);
        end
    end
`endif

    initial begin
        logic a;
        int   n;
        int   k;
        int   exp_acc;

        do_reset();

        // Single word: the output appears exactly DEPTH+1 cycles later for one cycle.
        drive(1'b1, 8'h00, 1'b1, a);
        check("t1_accept", a, 1);
        for (int i = 1; i <= DEPTH + 2; i++) begin
            drive(1'b0, '0, 1'b1, a);
            check("t1_out_valid", out_valid, 32'(i == DEPTH + 1));
        end
        drain();

        // Wrap-around cases.
        drive(1'b1, 8'hFE, 1'b1, a);
        check("t2_accept_fe", a, 1);
        drive(1'b1, 8'h7F, 1'b1, a);
        check("t2_accept_7f", a, 1);
        drain();

        // Back-pressure: offer 10..14 while the consumer stalls.
        n = 0;
        for (int c = 0; c < DEPTH + 5; c++) begin
            if (n < 5) begin
                drive(1'b1, W'(10 + n), 1'b0, a);
                if (a) n++;
            end else begin
                drive(1'b0, '0, 1'b0, a);
            end
        end
        exp_acc = (DEPTH + 1 < 5) ? DEPTH + 1 : 5;
        check("t3_accepted", n, exp_acc);
        check("t3_in_ready", in_ready, 32'(5 < DEPTH + 1));
        k = 0;
        while (n < 5 && k < 50) begin
            drive(1'b1, W'(10 + n), 1'b1, a);
            if (a) n++;
            k++;
        end
        check("t3_all_sent", n, 5);
        drain();

        // Streaming 20 back-to-back words.
        max_run = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'($urandom), 1'b1, a);
            check("t4_in_ready", a, 1);
        end
        drain();
        check("t4_consecutive", max_run, 20);

        // Reset with words in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'($urandom_range(0, 255)), 1'b1, a);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1, a);
            check("t5_idle_valid", out_valid, 0);
        end
        drive(1'b1, 8'h00, 1'b1, a);
        check("t5_accept", a, 1);
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), a);
        end
        drain();

        check("final_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
